// File: rtl/tick_counter_if.sv
// Control and count signals for tick_counter, with master (driver) and slave (counter) views.
// TICK_COUNTER_SEG_EN adds blank_lz_i and seg_o for the seven-segment variant.
interface tick_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    slow_i;
  logic                    start_stop_i;
  logic                    clear_i;
  logic                    dir_i;
  logic [4*NUM_DIGITS-1:0] count_o;
  logic                    running_o;
  logic                    wrap_o;
`ifdef TICK_COUNTER_SEG_EN
  logic                    blank_lz_i;
  logic [7*NUM_DIGITS-1:0] seg_o;

  modport master (
    output slow_i, start_stop_i, clear_i, dir_i, blank_lz_i,
    input  count_o, running_o, wrap_o, seg_o
  );
  modport slave (
    input  slow_i, start_stop_i, clear_i, dir_i, blank_lz_i,
    output count_o, running_o, wrap_o, seg_o
  );
`else
  modport master (
    output slow_i, start_stop_i, clear_i, dir_i,
    input  count_o, running_o, wrap_o
  );
  modport slave (
    input  slow_i, start_stop_i, clear_i, dir_i,
    output count_o, running_o, wrap_o
  );
`endif
endinterface

// File: rtl/tick_counter.sv
// Multi-digit BCD up/down counter advanced by rising edges of the divided clock level.
// Define TICK_COUNTER_SEG_EN to add registered active-low seven-segment outputs with leading-zero blanking.
module tick_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tick_counter_if.slave  bus
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            slow_q_reg;
  logic            tick;
  logic            count_en;
  logic [W-1:0]    count_reg, count_next;
  logic [W-1:0]    step_value;
  logic [NUM_DIGITS:0] carry;
  logic            running_reg, running_next;
  logic            wrap_reg, wrap_next;

  assign tick     = bus.slow_i & ~slow_q_reg;
  // clear_i overrides any step, so it also suppresses the wrap pulse
  assign count_en = (state_reg == RUN) & tick & ~bus.clear_i;

  // Ripple carry/borrow chain across digits; digit 0 always steps when enabled.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] digit_step;
      logic       carry_out;

      assign digit = count_reg[4*gi +: 4];

      always_comb begin
        digit_step = digit;
        carry_out  = 1'b0;
        if (carry[gi]) begin
          if (!bus.dir_i) begin
            if (digit == 4'd9) begin
              digit_step = 4'd0;
              carry_out  = 1'b1;
            end else begin
              digit_step = digit + 4'd1;
            end
          end else begin
            if (digit == 4'd0) begin
              digit_step = 4'd9;
              carry_out  = 1'b1;
            end else begin
              digit_step = digit - 4'd1;
            end
          end
        end
      end

      assign step_value[4*gi +: 4] = digit_step;
      assign carry[gi+1]           = carry_out;
    end
  endgenerate

  // State register plus count datapath.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_reg   <= IDLE;
      slow_q_reg  <= 1'b1;
      count_reg   <= '0;
      running_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      slow_q_reg  <= bus.slow_i;
      count_reg   <= count_next;
      running_reg <= running_next;
      wrap_reg    <= wrap_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (bus.clear_i) begin
      state_next = IDLE;
    end else if (bus.start_stop_i) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: registered state decode, next count and wrap flag.
  always_comb begin
    running_next = (state_next == RUN);
    count_next   = count_reg;
    wrap_next    = 1'b0;
    if (bus.clear_i) begin
      count_next = '0;
    end else if (count_en) begin
      count_next = step_value;
      wrap_next  = carry[NUM_DIGITS];
    end
  end

  assign bus.count_o   = count_reg;
  assign bus.running_o = running_reg;
  assign bus.wrap_o    = wrap_reg;

`ifdef TICK_COUNTER_SEG_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Decode the value being loaded into count_reg so seg_o tracks count_o with no extra lag.
  logic [W-1:0]            seg_count;
  logic [7*NUM_DIGITS-1:0] seg_next, seg_reg;
  logic [NUM_DIGITS:0]     lead_zero;

  assign seg_count             = rst_ni ? '0 : count_next;
  assign lead_zero[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      assign lead_zero[gi] = lead_zero[gi+1] & (seg_count[4*gi +: 4] == 4'd0);
      if (gi == 0) begin : g_lsd
        assign seg_next[6:0] = seg_decode(seg_count[3:0]);
      end else begin : g_upper
        assign seg_next[7*gi +: 7] = (bus.blank_lz_i && lead_zero[gi]) ? 7'h7F
                                                                        : seg_decode(seg_count[4*gi +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    seg_reg <= seg_next;
  end

  assign bus.seg_o = seg_reg;
`endif

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter: directed scenarios plus randomized traffic against
// an integer-valued reference model (TICK_COUNTER_SEG_EN also enables seven-segment checks).
module tb_tick_counter;

  localparam int ND   = 4;
  localparam int W    = 4 * ND;
  localparam int MAXV = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_counter_if #(.NUM_DIGITS(ND)) bus ();

  tick_counter #(.NUM_DIGITS(ND)) dut (
    .clk_i  (clk),
    .rst_ni (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: count kept as a plain integer, state as 0=idle 1=run 2=pause.
  int m_count   = 0;
  int m_state   = 0;
  bit m_slow_q  = 1'b1;
  bit m_wrap    = 1'b0;
  bit m_running = 1'b0;
  bit blank     = 1'b0;
`ifdef TICK_COUNTER_SEG_EN
  logic [7*ND-1:0] m_seg;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

`ifdef TICK_COUNTER_SEG_EN
  function automatic logic [7*ND-1:0] model_seg(input int v, input bit blank_lz);
    logic [7*ND-1:0] r;
    logic [6:0] table_seg [10];
    int digits [ND];
    int t;
    bit lead;
    table_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    t = v;
    for (int i = 0; i < ND; i++) begin
      digits[i] = t % 10;
      t = t / 10;
    end
    lead = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      lead = lead && (digits[i] == 0);
      r[7*i +: 7] = (blank_lz && lead && i != 0) ? 7'h7F : table_seg[digits[i]];
    end
    return r;
  endfunction
`endif

  task automatic model_update();
    bit tk;
    tk = bus.slow_i && !m_slow_q;
    if (rst) begin
      m_state = 0; m_count = 0; m_wrap = 0; m_slow_q = 1'b1;
    end else begin
      m_slow_q = bus.slow_i;
      m_wrap   = 1'b0;
      if (bus.clear_i) begin
        m_state = 0; m_count = 0;
      end else begin
        if (m_state == 1 && tk) begin
          if (!bus.dir_i) begin
            if (m_count == MAXV) begin m_count = 0; m_wrap = 1'b1; end
            else m_count = m_count + 1;
          end else begin
            if (m_count == 0) begin m_count = MAXV; m_wrap = 1'b1; end
            else m_count = m_count - 1;
          end
        end
        if (bus.start_stop_i) m_state = (m_state == 1) ? 2 : 1;
      end
    end
    m_running = (m_state == 1);
`ifdef TICK_COUNTER_SEG_EN
    m_seg = model_seg(m_count, blank);
`endif
  endtask

  task automatic cycle(input bit r, input bit slow, input bit ss, input bit clr, input bit dir);
    rst              = r;
    bus.slow_i       = slow;
    bus.start_stop_i = ss;
    bus.clear_i      = clr;
    bus.dir_i        = dir;
`ifdef TICK_COUNTER_SEG_EN
    bus.blank_lz_i   = blank;
`endif
    @(posedge clk);
    model_update();
    #1;
    check_eq("count", 64'(bus.count_o), 64'(to_bcd(m_count)));
    check_eq("running", 64'(bus.running_o), 64'(m_running));
    check_eq("wrap", 64'(bus.wrap_o), 64'(m_wrap));
`ifdef TICK_COUNTER_SEG_EN
    check_eq("seg", 64'(bus.seg_o), 64'(m_seg));
`endif
  endtask

  task automatic tick_once(input bit dir);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, dir);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, dir);
  endtask

  initial begin
    bit slow_r, dir_r;
    bus.slow_i = 1'b1; bus.start_stop_i = 1'b0; bus.clear_i = 1'b0; bus.dir_i = 1'b0;
`ifdef TICK_COUNTER_SEG_EN
    bus.blank_lz_i = 1'b0;
`endif

    // Reset with slow high, then start and hold slow high: no spurious tick.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("reset_count", 64'(bus.count_o), 64'h0);
    check_eq("reset_running", 64'(bus.running_o), 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("no_spurious_tick", 64'(bus.count_o), 64'h0);
    check_eq("running_after_start", 64'(bus.running_o), 64'h1);
    $display("txn: reset/start count=%h running=%0b", bus.count_o, bus.running_o);

    // Twelve rising edges counting up.
    for (int i = 0; i < 12; i++) tick_once(1'b0);
    check_eq("count_12", 64'(bus.count_o), 64'h0012);
    $display("txn: 12 ticks up count=%h", bus.count_o);

    // Wrap in both directions.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_once(1'b1);
    check_eq("wrap_down_count", 64'(bus.count_o), 64'h9999);
    check_eq("wrap_down_pulse", 64'(bus.wrap_o), 64'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_one_cycle", 64'(bus.wrap_o), 64'h0);
    tick_once(1'b0);
    check_eq("wrap_up_count", 64'(bus.count_o), 64'h0000);
    check_eq("wrap_up_pulse", 64'(bus.wrap_o), 64'h1);
    $display("txn: wrap checks count=%h", bus.count_o);

    // Step and pause together at 0009, then ticks are dropped in PAUSE.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick_once(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("step_and_pause", 64'(bus.count_o), 64'h0010);
    check_eq("paused", 64'(bus.running_o), 64'h0);
    for (int i = 0; i < 3; i++) tick_once(1'b0);
    check_eq("pause_drops_ticks", 64'(bus.count_o), 64'h0010);
    $display("txn: pause count=%h", bus.count_o);

    // Clear beats start_stop and tick.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("clear_count", 64'(bus.count_o), 64'h0);
    check_eq("clear_running", 64'(bus.running_o), 64'h0);
    check_eq("clear_wrap", 64'(bus.wrap_o), 64'h0);
    $display("txn: clear count=%h running=%0b", bus.count_o, bus.running_o);

`ifdef TICK_COUNTER_SEG_EN
    blank = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 42; i++) tick_once(1'b0);
    check_eq("seg_0042", 64'(bus.seg_o), 64'({7'h7F, 7'h7F, 7'h19, 7'h24}));
    $display("txn: seg count=%h seg=%h", bus.count_o, bus.seg_o);
`endif

    // Randomized traffic, including occasional mid-operation reset.
    dir_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      slow_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) dir_r = ~dir_r;
`ifdef TICK_COUNTER_SEG_EN
      if ($urandom_range(0, 31) == 0) blank = ~blank;
`endif
      cycle(($urandom_range(0, 499) == 0), slow_r, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 299) == 0), dir_r);
    end
    $display("txn: random phase done count=%h", bus.count_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Consumes the slow divided clock (`clk_div_o`) from the clock divider as a level signal sampled in the `clk_i` domain.
- Detects each rising edge of that signal, producing one tick per slow period.
- Drives a multi-digit BCD up/down counter with start/stop and clear controls.
- Its output feeds the board display logic (LEDs / seven-segment).

Parameters:
- NUM_DIGITS, 4, number of BCD digits; `count_o` width = 4*NUM_DIGITS.

Ports:
- clk_i  input  1  system clock; same clock as the divider.
- rst_ni  input  1  synchronous, active-high reset (1 = reset). Name matches the divider's reset port.
- slow_i  input  1  divided clock level from the divider; already registered in the `clk_i` domain, so no synchroniser.
- start_stop_i  input  1  single-cycle pulse; toggles run/pause.
- clear_i  input  1  single-cycle pulse; zeroes count and returns to IDLE.
- dir_i  input  1  0 = count up, 1 = count down; sampled on each tick.
- count_o  output  4*NUM_DIGITS  packed BCD count; digit 0 = bits [3:0] (least significant).
- running_o  output  1  1 while state = RUN.
- wrap_o  output  1  one-cycle pulse when the count wraps.

Behaviour:
- Reset values (rst_ni=1 at a posedge):
  - state = IDLE; count_o = 0; running_o = 0; wrap_o = 0.
  - slow_q = 1. This blocks a spurious tick if slow_i is already high when reset releases.
- Edge detect:
  - slow_q <= slow_i every cycle.
  - tick = slow_i & ~slow_q (combinational).
  - Exactly one tick per 0->1 transition of slow_i.
- States:
  - IDLE: start_stop_i -> RUN.
  - RUN: start_stop_i -> PAUSE.
  - PAUSE: start_stop_i -> RUN.
  - clear_i in any state -> IDLE, count = 0.
- Counting:
  - Only when the current state (before the edge) is RUN and tick = 1.
  - count_o updates at that posedge and is visible the next cycle (1-cycle latency from tick).
  - Ticks in IDLE/PAUSE are dropped, not queued.
- BCD arithmetic:
  - Up: a digit at 9 becomes 0 and carries into the next digit.
  - Down: a digit at 0 becomes 9 and borrows from the next digit.
  - No digit ever holds A-F.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - wrap_o = 1 in the same cycle the wrapped value appears on count_o, and 0 otherwise.
- Simultaneous events:
  - clear_i beats tick and start_stop_i: count = 0, state = IDLE, wrap_o = 0.
  - RUN + tick + start_stop_i: the count step is applied AND the state goes to PAUSE.
  - PAUSE + tick + start_stop_i: no count step; the state goes to RUN.
- Reset mid-operation: count and state are zeroed at the next posedge regardless of any pending tick or control input.
- dir_i may change at any time; only its value at the tick cycle matters.
- running_o is a registered decode of state.

Optional Feature:
- Macro: `TICK_COUNTER_SEG_EN`.
- When defined:
  - Adds output `seg_o [7*NUM_DIGITS-1:0]`: per-digit active-low seven-segment patterns (gfedcba), registered, updated the same cycle as count_o.
  - Adds input `blank_lz_i`: when 1, leading zero digits are blanked (all segments off, 7'h7F). Digit 0 is never blanked.
  - seg_o reset value = pattern for all zeros, with blanking applied per blank_lz_i.
- When undefined: neither port exists and there is no decode logic.

Test Plan:
- Reset with slow_i held 1, release, start_stop_i pulse, keep slow_i=1 for 5 cycles -> count_o stays 16'h0000 (no spurious tick), running_o = 1.
- RUN, dir_i=0, apply 12 slow_i rising edges -> count_o = 16'h0012. Each step appears exactly 1 cycle after its tick cycle.
- RUN, preload by counting to 16'h9999, one more tick -> count_o = 16'h0000 with wrap_o = 1 for exactly 1 cycle. Then dir_i=1 and one tick -> 16'h9999 with wrap_o pulse.
- RUN at 16'h0009 with start_stop_i and tick in the same cycle -> count_o = 16'h0010, state PAUSE. Three further ticks -> count_o unchanged at 16'h0010.
- PAUSE at 16'h0010 with clear_i and start_stop_i and tick in the same cycle -> count_o = 0, running_o = 0, state IDLE, wrap_o = 0.
- `TICK_COUNTER_SEG_EN` defined, NUM_DIGITS=4, count 16'h0042, blank_lz_i = 1 -> digits 3..2 = 7'h7F, digit1 = "4" (7'h19), digit0 = "2" (7'h24).
